// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } seq_state_e;

    localparam int ZERO_REG = 0;

    function automatic int addr_width(input int nregs);
        if (nregs <= 2) begin
            return 1;
        end else begin
            return $clog2(nregs);
        end
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps zeroes into entries 1..NREGS-1 after reset or clr_req, then raises ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // Next-state and sweep counter; a request always restarts the sweep at entry 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_req) begin
                    cnt_d = FIRST_IDX;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = FIRST_IDX;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = FIRST_IDX;
            end
        endcase
    end

    // Sequencer state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready    = (state_q == READY);
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, NWR writes, optional write-first bypass, x0 hardwired.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data
);

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_REG);

    logic            clr_we_s;
    logic [AW-1:0]   clr_addr_s;
    logic [NWR-1:0]  wr_acc_s;
    logic [AW-1:0]   wa_s [NWR];
    logic [XLEN-1:0] wd_s [NWR];
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    regfile_clear_seq #(.NREGS(NREGS), .AW(AW)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // Unpack write ports and qualify them; the clr_req cycle accepts no user write.
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            wa_s[p]     = wr_addr[p*AW +: AW];
            wd_s[p]     = wr_data[p*XLEN +: XLEN];
            wr_acc_s[p] = ready && !clr_req && wr_en[p] &&
                          (wa_s[p] != ZERO_A) && ({1'b0, wa_s[p]} < NREGS_W);
        end
    end

    // Array update: the sweep write takes priority, then user ports in ascending order so the highest wins.
    always_comb begin
        regs_d = regs_q;
        if (clr_we_s) begin
            regs_d[clr_addr_s] = '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                regs_d[wa_s[p]] = wr_acc_s[p] ? wd_s[p] : regs_d[wa_s[p]];
            end
        end
    end

    // Storage carries no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra_s;
        logic [XLEN-1:0] rdv_s;

        assign ra_s = rd_addr[k*AW +: AW];

        // Read mux: zero when not ready, x0 or out of range; otherwise array or highest matching write.
        always_comb begin
            rdv_s = '0;
            if (ready && (ra_s != ZERO_A) && ({1'b0, ra_s} < NREGS_W)) begin
                rdv_s = regs_q[ra_s];
                for (int p = 0; p < NWR; p++) begin
                    rdv_s = ((BYPASS != 0) && wr_acc_s[p] && (wa_s[p] == ra_s)) ? wd_s[p] : rdv_s;
                end
            end else begin
                rdv_s = '0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = rdv_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a 32-entry write-first instance and a 24-entry read-old instance share stimulus.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr_req;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                ready_a, ready_b;
    logic [NRD*XLEN-1:0] rd_data_a, rd_data_b;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_a), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(24), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        string       tag;
        int          inst;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem [2][32];
    bit          rdy [2];
    int          left [2];
    int          nregs [2] = '{32, 24};
    bit          byp [2]   = '{1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i, input logic [AW-1:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (rdy[i] && a != 5'd0 && int'(a) < nregs[i]) begin
            v = mem[i][a];
            if (byp[i] && !clr_req) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*XLEN +: XLEN];
                end
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] actual(input int i, input int port);
        logic [31:0] v;
        if (port == 2) v = {31'd0, (i == 0) ? ready_a : ready_b};
        else if (i == 0) v = rd_data_a[port*XLEN +: XLEN];
        else v = rd_data_b[port*XLEN +: XLEN];
        return v;
    endfunction

    task automatic model_reset(input int i);
        rdy[i]  = 1'b0;
        left[i] = nregs[i] - 1;
        for (int r = 0; r < 32; r++) mem[i][r] = 32'h0;
    endtask

    // Behavioural model of one rising edge, using the inputs as driven.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                model_reset(i);
            end else if (rdy[i]) begin
                if (clr_req) begin
                    model_reset(i);
                end else begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en[p] && wr_addr[p*AW +: AW] != 5'd0 && int'(wr_addr[p*AW +: AW]) < nregs[i])
                            mem[i][wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
                    end
                end
            end else if (clr_req) begin
                left[i] = nregs[i] - 1;
            end else begin
                left[i]--;
                if (left[i] == 0) rdy[i] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit req, input logic [1:0] wen,
                        input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        clr_req = req;
        wr_en   = wen;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0};
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{$sformatf("rd%0d_p0_a%0d", i, ra0), i, 0, exp_rd(i, ra0)});
            sb_q.push_back('{$sformatf("rd%0d_p1_a%0d", i, ra1), i, 1, exp_rd(i, ra1)});
            sb_q.push_back('{$sformatf("ready%0d", i), i, 2, {31'd0, rdy[i]}});
        end
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, actual(e.inst, e.port), e.exp);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] ra0, input logic [4:0] ra1);
        for (int c = 0; c < n; c++) step(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, ra0, ra1);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("async_ready0", {31'd0, ready_a}, 32'h0);
        chk("async_ready1", {31'd0, ready_b}, 32'h0);
        chk("async_rd0", rd_data_a[31:0], 32'h0);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic fill();
        for (int r = 1; r < 32; r++)
            step(1'b0, 2'b01, 5'(r), 32'hA500_0000 | r, 5'd0, 32'h0, 5'(r), 5'(r - 1));
    endtask

    task automatic readback();
        for (int r = 0; r < 32; r++) step(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(r), 5'(31 - r));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; clr_req = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        model_reset(0);
        model_reset(1);
        @(posedge clk); #1;
        idle(3, 5'd5, 5'd5);
        rst = 1'b1;
        // sweep after reset; writes to x7 during the sweep must be lost
        for (int c = 0; c < 31; c++)
            step(1'b0, (c < 20) ? 2'b01 : 2'b00, 5'd7, 32'h0000_AAAA, 5'd0, 32'h0, 5'd5, 5'd5);
        idle(2, 5'd7, 5'd5);
        // basic write/read with and without bypass
        step(1'b0, 2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd3, 5'd3);
        idle(1, 5'd3, 5'd0);
        // x0 stays zero even with both ports writing it
        step(1'b0, 2'b11, 5'd0, 32'h1234_5678, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        idle(1, 5'd0, 5'd3);
        // port conflict: the higher port wins
        step(1'b0, 2'b11, 5'd9, 32'h0000_0011, 5'd9, 32'h0000_0022, 5'd9, 5'd9);
        idle(1, 5'd9, 5'd9);
        // out-of-range write to the 24-entry instance is dropped
        step(1'b0, 2'b10, 5'd0, 32'h0, 5'd30, 32'h3030_3030, 5'd30, 5'd30);
        idle(1, 5'd30, 5'd23);
        // fill, then a full clear sweep
        fill();
        readback();
        step(1'b1, 2'b01, 5'd4, 32'hBAD0_0004, 5'd0, 32'h0, 5'd4, 5'd1);
        idle(32, 5'd4, 5'd31);
        readback();
        // second clr_req at sweep cycle 10 restarts the sweep
        fill();
        step(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd20);
        idle(9, 5'd2, 5'd20);
        step(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd20);
        idle(32, 5'd2, 5'd20);
        readback();
        // async reset while ready, then mid-sweep after release
        fill();
        async_reset();
        rst = 1'b1;
        idle(5, 5'd6, 5'd17);
        async_reset();
        idle(2, 5'd6, 5'd17);
        rst = 1'b1;
        idle(33, 5'd6, 5'd17);
        readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the successor to the single-issue 32 x 32 regfile. It has NRD combinational read ports, NWR synchronous write ports, and optional write-to-read bypass, so the ID stage no longer needs the negedge-write trick. Register 0 is hardwired to zero. A hardware clear sequencer zeroes the array after reset or on request and holds `ready` low until the sweep finishes. The block sits between the decode stage (reads) and the writeback stage (writes).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (2..256; need not be a power of two)
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- BYPASS, 1, 1 = write-first (same-cycle write visible on reads), 0 = read-old
- AW, derived = $clog2(NREGS), address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clr_req  in  1  synchronous request to re-zero the whole array
- ready  out  1  1 = array valid, writes accepted
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses, packed as for reads
- wr_data  in  NWR*XLEN  write data, packed as for reads

## Operation
- The array is plain storage with no reset. Only the sequencer state and its counter are reset.
- **Sequencer states:** CLEAR and READY.
- **Entering CLEAR:**
  - While rst=0: state = CLEAR, counter = 1, ready = 0, asynchronously.
  - In CLEAR, each cycle writes regs[counter] = 0 and increments counter.
  - When counter = NREGS-1 and that entry has been written, the next state is READY.
- **clr_req:**
  - In READY: goes to CLEAR with counter = 1 on the next edge.
  - In CLEAR: restarts counter at 1.
- **Writes:**
  - Port p writes when ready=1, wr_en[p]=1, wr_addr≠0 and wr_addr<NREGS.
  - Any other write is dropped silently.
  - Writes are ignored entirely while ready=0, including the cycle in which clr_req is sampled.
- **Write conflict:** if two ports target the same address in one cycle, the higher port index wins.
- **Reads** are combinational:
  - rd_data = 0 if ready=0, addr=0, or addr≥NREGS.
  - Otherwise regs[addr].
  - With BYPASS=1, if any enabled, accepted write targets the same address this cycle, rd_data returns that wr_data. If several match, the highest port index wins.
- Address 0 always reads 0, whatever writes or bypass are present.

## Timing
- Reset values: ready=0, state=CLEAR, counter=1. rd_data=0 for every port while ready=0.
- Clear latency is NREGS-1 cycles from the first rising edge after rst deasserts to the rising edge that sets ready=1. For NREGS=32 this is 31 cycles.
- clr_req asserted at edge n (sampled in READY): ready=0 after edge n, ready=1 after edge n+NREGS-1.
- Write latency:
  - Data accepted at edge n is visible in the array after edge n.
  - BYPASS=1: also visible combinationally during cycle n.
  - BYPASS=0: readable only from cycle n+1.
- Reset asserted mid-sweep or mid-write aborts immediately. Any partial array contents are undefined until the next sweep completes.
- All read paths are purely combinational from rd_addr, wr_* and ready. No read path goes through clk.

## Structure
- **regfile_pkg** holds:
  - the state enum (CLEAR, READY);
  - an address-width helper function;
  - a constant ZERO_REG = 0.
- **regfile_clear_seq** is the sub-module for the FSM and sweep counter.
  - Inputs: clk, rst, clr_req.
  - Outputs: ready, clr_we, clr_addr.
- The top level contains:
  - the storage array;
  - the write-port arbitration, which muxes the clear write in ahead of the user ports;
  - the bypass/read muxes, generated per port.

## Test plan
- **Reset and sweep:** release rst, with reads on all ports at addr 5.
  - ready rises exactly 31 cycles later.
  - rd_data = 0 throughout.
  - Writes issued during the sweep are lost: after ready, reading addr 7 returns 0.
- **Basic write/read:** write 0xDEADBEEF to x3.
  - BYPASS=1: rd_data = 0xDEADBEEF in the same cycle.
  - BYPASS=0: old value 0 in that cycle, 0xDEADBEEF in the next.
- **x0 hardwiring:** write 0x12345678 to x0 on both ports.
  - x0 reads 0, including in the bypass cycle.
- **Port conflict (NWR=2):** port0 writes 0x11 and port1 writes 0x22 to x9 in the same cycle.
  - Same-cycle bypass read returns 0x22.
  - Later reads of x9 return 0x22.
- **clr_req:**
  - After filling x1..x31 with nonzero data, pulse clr_req: ready drops for 31 cycles, then every register reads 0.
  - A second clr_req at sweep cycle 10 extends the sweep to 10+31 cycles.
- **Async reset mid-sweep, and out-of-range addresses (NREGS=24):**
  - Assert rst at sweep cycle 5: ready=0 immediately, and a full sweep follows release.
  - With NREGS=24, reading or writing addr 30 returns 0 and the write is dropped.
